// File: rtl/edge_window_pkg.sv
// Shared types for the edge window checker: channel and top-level state encodings
// and the default tick counter width.
package edge_window_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    CH_WAIT,
    CH_OK,
    CH_FAIL
  } ch_state_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } top_state_e;

endpackage

// File: rtl/edge_window_ch.sv
// One monitored channel: waits for the first departure from the reference level and
// grades it against [lo, hi]. Glitch checking is built only with EDGE_WINDOW_GLITCH_CHECK_EN.
module edge_window_ch
  import edge_window_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] tick,
  input  logic [CNT_W-1:0] lo,
  input  logic [CNT_W-1:0] hi,
  input  logic             ref_lvl,
  input  logic             sig,
  input  logic             run,
  input  logic             run_start,
  output logic             early,
  output logic             late,
  output logic             glitch
);

  ch_state_e r_state;
  ch_state_e w_state_nxt;
  logic      r_early;
  logic      r_late;
  logic      w_early_set;
  logic      w_late_set;
  logic      w_glitch_set;

  always_comb begin
    w_state_nxt  = r_state;
    w_early_set  = 1'b0;
    w_late_set   = 1'b0;
    w_glitch_set = 1'b0;
    if (run) begin
      case (r_state)
        CH_WAIT: begin
          // An inverted window can never be met, so it fails as late immediately.
          if ((lo > hi) || (tick > hi)) begin
            w_late_set  = 1'b1;
            w_state_nxt = CH_FAIL;
          end else if (sig != ref_lvl) begin
            if (tick < lo) begin
              w_early_set = 1'b1;
              w_state_nxt = CH_FAIL;
            end else begin
              w_state_nxt = CH_OK;
            end
          end
        end
        CH_OK: begin
`ifdef EDGE_WINDOW_GLITCH_CHECK_EN
          if (sig == ref_lvl) begin
            w_glitch_set = 1'b1;
            w_state_nxt  = CH_FAIL;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_WAIT;
      r_early <= 1'b0;
      r_late  <= 1'b0;
    end else if (run_start) begin
      r_state <= CH_WAIT;
      r_early <= 1'b0;
      r_late  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_early_set) r_early <= 1'b1;
      if (w_late_set)  r_late  <= 1'b1;
    end
  end

  // Current-cycle causes are OR'd in so a failure on the final run cycle still reaches pass.
  assign early = r_early | w_early_set;
  assign late  = r_late  | w_late_set;

`ifdef EDGE_WINDOW_GLITCH_CHECK_EN
  logic r_glitch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch <= 1'b0;
    end else if (run_start) begin
      r_glitch <= 1'b0;
    end else if (w_glitch_set) begin
      r_glitch <= 1'b1;
    end
  end

  assign glitch = r_glitch | w_glitch_set;
`else
  assign glitch = w_glitch_set;
`endif

endmodule

// File: rtl/edge_window_checker.sv
// Arms on start, counts ticks, and grades each channel's first transition against its
// window. Optional glitch checking: define EDGE_WINDOW_GLITCH_CHECK_EN.
module edge_window_checker
  import edge_window_pkg::*;
#(
  parameter int N_CH  = 3,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_CH-1:0]       sig_in,
  input  logic [N_CH*CNT_W-1:0] win_lo,
  input  logic [N_CH*CNT_W-1:0] win_hi,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_CH-1:0]       early_mask,
  output logic [N_CH-1:0]       late_mask,
  output logic [N_CH-1:0]       glitch_mask
);

  top_state_e            r_state;
  top_state_e            w_state_nxt;
  logic [CNT_W-1:0]      r_tick;
  logic [N_CH-1:0]       r_ref;
  logic [N_CH*CNT_W-1:0] r_lo;
  logic [N_CH*CNT_W-1:0] r_hi;
  logic [CNT_W-1:0]      w_max_hi;
  logic [CNT_W:0]        w_end_tick;
  logic                  w_run;
  logic                  w_accept;
  logic                  w_end;

  always_comb begin
    w_max_hi = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_hi[k*CNT_W +: CNT_W] > w_max_hi) w_max_hi = r_hi[k*CNT_W +: CNT_W];
    end
  end

  assign w_end_tick = {1'b0, w_max_hi} + {{CNT_W{1'b0}}, 1'b1};
  assign w_run      = (r_state == ST_RUN);
  assign w_accept   = (r_state == ST_IDLE) && start;
  // A window ending at the counter ceiling would never see hi+1; end at saturation instead.
  assign w_end      = w_run && (({1'b0, r_tick} == w_end_tick) || ((&r_tick) && (&w_max_hi)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_end) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
    end else if (w_accept) begin
      r_tick <= '0;
    end else if (w_run && !(&r_tick)) begin
      r_tick <= r_tick + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ref <= sig_in;
      r_lo  <= win_lo;
      r_hi  <= win_hi;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    edge_window_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (r_tick),
      .lo       (r_lo[k*CNT_W +: CNT_W]),
      .hi       (r_hi[k*CNT_W +: CNT_W]),
      .ref_lvl  (r_ref[k]),
      .sig      (sig_in[k]),
      .run      (w_run),
      .run_start(w_accept),
      .early    (early_mask[k]),
      .late     (late_mask[k]),
      .glitch   (glitch_mask[k])
    );
  end

  assign busy = w_run;
  assign done = w_end;
  assign pass = w_end && !(|{early_mask, late_mask, glitch_mask});

endmodule

// File: tb/tb_edge_window_checker.sv
// Directed bench for edge_window_checker: pass, early, late, inverted window, glitch,
// start while busy, start on done, and reset mid-run.
module tb_edge_window_checker;

  localparam int N_CH  = 3;
  localparam int CNT_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  start = 1'b0;
  logic [N_CH-1:0]       sig_in = '0;
  logic [N_CH*CNT_W-1:0] win_lo = '0;
  logic [N_CH*CNT_W-1:0] win_hi = '0;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [N_CH-1:0]       early_mask;
  logic [N_CH-1:0]       late_mask;
  logic [N_CH-1:0]       glitch_mask;

  int checks = 0;
  int errors = 0;
  int rise_t[N_CH];
  int fall_t[N_CH];
  logic [N_CH-1:0] ref_v;

  always #5 clk = ~clk;

  edge_window_checker #(
    .N_CH (N_CH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .sig_in     (sig_in),
    .win_lo     (win_lo),
    .win_hi     (win_hi),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .early_mask (early_mask),
    .late_mask  (late_mask),
    .glitch_mask(glitch_mask)
  );

  task automatic set_win(input int k, input int lo, input int hi);
    win_lo[k*CNT_W +: CNT_W] = CNT_W'(lo);
    win_hi[k*CNT_W +: CNT_W] = CNT_W'(hi);
  endtask

  task automatic setup_nominal();
    ref_v = 3'b000;
    rise_t[0] = 10;  fall_t[0] = -1;
    rise_t[1] = 100; fall_t[1] = -1;
    rise_t[2] = 100; fall_t[2] = -1;
    set_win(0, 9, 11);
    set_win(1, 99, 101);
    set_win(2, 99, 101);
  endtask

  function automatic logic [N_CH-1:0] drive_val(input int c);
    logic [N_CH-1:0] v;
    for (int k = 0; k < N_CH; k++) begin
      v[k] = ref_v[k] ^ ((rise_t[k] >= 0) && (c >= rise_t[k]) && ((fall_t[k] < 0) || (c < fall_t[k])));
    end
    return v;
  endfunction

  // Arms one run and steps it tick by tick; dt stays -1 if done never arrives.
  task automatic run(input int restart_at, input int max_cyc, output int dt, output logic p,
                     output logic [N_CH-1:0] e, output logic [N_CH-1:0] l,
                     output logic [N_CH-1:0] g, output logic [N_CH-1:0] e0,
                     output logic [N_CH-1:0] l0, output int busy_bad);
    dt = -1; p = 1'b0; e = '0; l = '0; g = '0; e0 = '0; l0 = '0; busy_bad = 0;
    @(posedge clk); #1;
    sig_in = ref_v;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      sig_in = drive_val(c);
      start  = (c == restart_at);
      @(negedge clk);
      if (c == 0) begin
        e0 = early_mask;
        l0 = late_mask;
      end
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        dt = c; p = pass; e = early_mask; l = late_mask; g = glitch_mask;
      end
      @(posedge clk); #1;
      if (dt >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset.done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset.pass got %b want 0", pass); end
    checks++;
    if ({early_mask, late_mask, glitch_mask} !== '0) begin
      errors++; $display("FAIL reset.masks got %b want 0", {early_mask, late_mask, glitch_mask});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_pass(input string nm);
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    setup_nominal();
    run(-1, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== 102) begin errors++; $display("FAIL %s.done_tick got %0d want 102", nm, dt); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL %s.pass got %b want 1", nm, p); end
    checks++; if ({e, l, g} !== '0) begin errors++; $display("FAIL %s.masks got %b want 0", nm, {e, l, g}); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL %s.busy_low got %0d want 0", nm, bb); end
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      errors++; $display("FAIL %s.after_done got %b want 000", nm, {busy, done, pass});
    end
  endtask

  task automatic test_early();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    setup_nominal();
    rise_t[0] = 5;
    run(-1, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== 102) begin errors++; $display("FAIL early.done_tick got %0d want 102", dt); end
    checks++; if (e !== 3'b001) begin errors++; $display("FAIL early.early_mask got %b want 001", e); end
    checks++; if (l !== 3'b000) begin errors++; $display("FAIL early.late_mask got %b want 000", l); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL early.pass got %b want 0", p); end
    @(negedge clk);
    checks++; if (early_mask !== 3'b001) begin errors++; $display("FAIL early.held got %b want 001", early_mask); end
  endtask

  task automatic test_late();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    setup_nominal();
    rise_t[1] = -1;
    run(-1, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (e0 !== 3'b000) begin errors++; $display("FAIL late.cleared_on_start got %b want 000", e0); end
    checks++; if (dt !== 102) begin errors++; $display("FAIL late.done_tick got %0d want 102", dt); end
    checks++; if (l !== 3'b010) begin errors++; $display("FAIL late.late_mask got %b want 010", l); end
    checks++; if (e !== 3'b000) begin errors++; $display("FAIL late.early_mask got %b want 000", e); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL late.pass got %b want 0", p); end
  endtask

  task automatic test_inverted_window();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    setup_nominal();
    set_win(0, 12, 11);
    run(-1, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (l0 !== 3'b001) begin errors++; $display("FAIL inverted.late_at_tick0 got %b want 001", l0); end
    checks++; if (dt !== 102) begin errors++; $display("FAIL inverted.done_tick got %0d want 102", dt); end
    checks++; if ({e, l} !== 6'b000001) begin errors++; $display("FAIL inverted.masks got %b want 000001", {e, l}); end
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL inverted.pass got %b want 0", p); end
  endtask

  task automatic test_glitch();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    logic [N_CH-1:0] g_exp;
    logic p_exp;
`ifdef EDGE_WINDOW_GLITCH_CHECK_EN
    g_exp = 3'b100; p_exp = 1'b0;
`else
    g_exp = 3'b000; p_exp = 1'b1;
`endif
    setup_nominal();
    fall_t[2] = 101;
    run(-1, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== 102) begin errors++; $display("FAIL glitch.done_tick got %0d want 102", dt); end
    checks++; if (g !== g_exp) begin errors++; $display("FAIL glitch.glitch_mask got %b want %b", g, g_exp); end
    checks++; if ({e, l} !== '0) begin errors++; $display("FAIL glitch.other_masks got %b want 0", {e, l}); end
    checks++; if (p !== p_exp) begin errors++; $display("FAIL glitch.pass got %b want %b", p, p_exp); end
  endtask

  task automatic test_ref_high();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    setup_nominal();
    ref_v = 3'b101;
    run(-1, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== 102) begin errors++; $display("FAIL ref_high.done_tick got %0d want 102", dt); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL ref_high.pass got %b want 1", p); end
    checks++; if ({e, l, g} !== '0) begin errors++; $display("FAIL ref_high.masks got %b want 0", {e, l, g}); end
  endtask

  task automatic test_start_while_busy();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    setup_nominal();
    run(50, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== 102) begin errors++; $display("FAIL busy_start.done_tick got %0d want 102", dt); end
    checks++; if (p !== 1'b1) begin errors++; $display("FAIL busy_start.pass got %b want 1", p); end
    checks++; if (bb !== 0) begin errors++; $display("FAIL busy_start.busy_low got %0d want 0", bb); end
    setup_nominal();
    run(102, 200, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== 102) begin errors++; $display("FAIL start_on_done.done_tick got %0d want 102", dt); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_on_done.busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    int dt; logic p; logic [N_CH-1:0] e, l, g, e0, l0; int bb;
    int done_seen;
    setup_nominal();
    rise_t[0] = 5;
    run(-1, 40, dt, p, e, l, g, e0, l0, bb);
    checks++; if (dt !== -1) begin errors++; $display("FAIL reset_run.premature_done got %0d want -1", dt); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_run.busy got %b want 0", busy); end
    checks++; if (early_mask !== 3'b000) begin errors++; $display("FAIL reset_run.early_mask got %b want 000", early_mask); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 120; c++) begin
      sig_in = drive_val(c + 40);
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL reset_run.no_done got %0d want 0", done_seen); end
    test_pass("reset_rerun");
  endtask

  initial begin
    test_reset();
    test_pass("pass");
    test_early();
    test_late();
    test_inverted_window();
    test_glitch();
    test_ref_high();
    test_start_while_busy();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
